axi_read_arbiter: RTL and testbench

- Shares the single CPU-side AXI read channel (AR + R) between up to N_MASTERS load requesters: I-cache refill, D-cache refill and the uncached loader.
- Each master uses a req/grnt handshake. The owner's AR/R signals are muxed through to the bus, and every master sees a global bus_busy flag.
- Sits between the MEM/IF-stage loaders and the top-level AXI crossbar/bridge.

---
 rtl/axi_arb_pkg.sv | 19 +
 rtl/rr_picker.sv | 27 ++
 rtl/axi_read_arbiter.sv | 141 ++++++++++++++
 tb/tb_axi_read_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the CPU-side AXI read arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam logic [1:0] AXI_ARLOCK    = 2'b00;
  localparam logic [3:0] AXI_ARCACHE   = 4'b0000;
  localparam logic [2:0] AXI_ARPROT    = 3'b000;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int MST_ICACHE   = 0;
  localparam int MST_DCACHE   = 1;
  localparam int MST_UNCACHED = 2;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at N.
module rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  int w_idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    w_idx  = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = (int'(ptr) + i) % N;
      if (!any && req[IDX_W'(w_idx)]) begin
        any    = 1'b1;
        winner = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Hands the single AXI read channel to one load requester at a time; the owner
// keeps it until it drops req and all of its bursts have returned rlast.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int N_MASTERS = 3,
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUT   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_MASTERS-1:0]     m_req,
  output logic [N_MASTERS-1:0]     m_grnt,
  output logic                     bus_busy,
  input  logic [N_MASTERS*ID_W-1:0]   m_arid,
  input  logic [N_MASTERS*ADDR_W-1:0] m_araddr,
  input  logic [N_MASTERS*4-1:0]   m_arlen,
  input  logic [N_MASTERS*3-1:0]   m_arsize,
  input  logic [N_MASTERS*2-1:0]   m_arburst,
  input  logic [N_MASTERS-1:0]     m_arvalid,
  output logic [N_MASTERS-1:0]     m_arready,
  output logic [DATA_W-1:0]        m_rdata,
  output logic [ID_W-1:0]          m_rid,
  output logic [1:0]               m_rresp,
  output logic                     m_rlast,
  output logic [N_MASTERS-1:0]     m_rvalid,
  input  logic [N_MASTERS-1:0]     m_rready,
  output logic [ID_W-1:0]          s_arid,
  output logic [ADDR_W-1:0]        s_araddr,
  output logic [3:0]               s_arlen,
  output logic [2:0]               s_arsize,
  output logic [1:0]               s_arburst,
  output logic [1:0]               s_arlock,
  output logic [3:0]               s_arcache,
  output logic [2:0]               s_arprot,
  output logic                     s_arvalid,
  input  logic                     s_arready,
  input  logic [ID_W-1:0]          s_rid,
  input  logic [DATA_W-1:0]        s_rdata,
  input  logic [1:0]               s_rresp,
  input  logic                     s_rlast,
  input  logic                     s_rvalid,
  output logic                     s_rready
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

  arb_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_owner, r_rr_ptr, w_winner;
  logic [CNT_W-1:0] r_out_cnt, w_cnt_nxt;
  logic             w_any, w_owned, w_cap_ok, w_ar_hs, w_rlast_hs;

  rr_picker #(.N(N_MASTERS), .IDX_W(IDX_W)) u_pick (
    .req    (m_req),
    .ptr    (r_rr_ptr),
    .winner (w_winner),
    .any    (w_any)
  );

  assign w_owned    = (r_state == OWNED);
  assign w_cap_ok   = (r_out_cnt < MAX_CNT);
  assign w_ar_hs    = w_owned & m_arvalid[r_owner] & w_cap_ok & s_arready;
  assign w_rlast_hs = w_owned & s_rvalid & m_rready[r_owner] & s_rlast;

  always_comb begin
    w_cnt_nxt = r_out_cnt;
    case ({w_ar_hs, w_rlast_hs})
      2'b10:   w_cnt_nxt = r_out_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_out_cnt - 1'b1;
      default: w_cnt_nxt = r_out_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_out_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_out_cnt <= w_cnt_nxt;
      if (r_state == IDLE && w_any)
        r_owner <= w_winner;
      if (r_state == RELEASE)
        r_rr_ptr <= (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
    end
  end

  // Release waits on the post-update count so a final rlast and req drop can coincide.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = OWNED;
      OWNED:   if (!m_req[r_owner] && w_cnt_nxt == '0) w_state_nxt = RELEASE;
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_grnt    = '0;
    bus_busy  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    s_rready  = 1'b0;
    s_arvalid = 1'b0;
    s_arid    = '0;
    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    if (w_owned) begin
      m_grnt[r_owner]    = 1'b1;
      bus_busy           = 1'b1;
      s_arid             = m_arid[int'(r_owner)*ID_W +: ID_W];
      s_araddr           = m_araddr[int'(r_owner)*ADDR_W +: ADDR_W];
      s_arlen            = m_arlen[int'(r_owner)*4 +: 4];
      s_arsize           = m_arsize[int'(r_owner)*3 +: 3];
      s_arburst          = m_arburst[int'(r_owner)*2 +: 2];
      s_arvalid          = m_arvalid[r_owner] & w_cap_ok;
      m_arready[r_owner] = s_arready & w_cap_ok;
      m_rvalid[r_owner]  = s_rvalid;
      s_rready           = m_rready[r_owner];
    end
  end

  assign m_rdata   = s_rdata;
  assign m_rid     = s_rid;
  assign m_rresp   = s_rresp;
  assign m_rlast   = s_rlast;
  assign s_arlock  = AXI_ARLOCK;
  assign s_arcache = AXI_ARCACHE;
  assign s_arprot  = AXI_ARPROT;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: arbitration table, directed corner sequences,
// and a randomized run against a grant/outstanding-queue reference model.
module tb_axi_read_arbiter;
  import axi_arb_pkg::*;

  localparam int N = 3, IW = 4, AW = 32, DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] m_req, m_grnt, m_arvalid, m_arready, m_rvalid, m_rready;
  logic bus_busy;
  logic [N*IW-1:0] m_arid;
  logic [N*AW-1:0] m_araddr;
  logic [N*4-1:0] m_arlen;
  logic [N*3-1:0] m_arsize;
  logic [N*2-1:0] m_arburst;
  logic [DW-1:0] m_rdata;
  logic [IW-1:0] m_rid;
  logic [1:0] m_rresp;
  logic m_rlast;
  logic [IW-1:0] s_arid;
  logic [AW-1:0] s_araddr;
  logic [3:0] s_arlen, s_arcache;
  logic [2:0] s_arsize, s_arprot;
  logic [1:0] s_arburst, s_arlock;
  logic s_arvalid, s_arready;
  logic [IW-1:0] s_rid;
  logic [DW-1:0] s_rdata;
  logic [1:0] s_rresp;
  logic s_rlast, s_rvalid, s_rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_read_arbiter #(.N_MASTERS(N), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(3)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_grnt(m_grnt), .bus_busy(bus_busy),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  typedef struct {
    int         pre;   // master granted and released first (-1: none), sets rr pointer
    logic [2:0] req;
    logic [2:0] exp;
  } arb_vec_t;

  arb_vec_t tbl[8];

  // reference model: grant holder plus a queue of outstanding bursts
  bit mo_owned, mo_rel;
  int mo_owner, mo_ptr;
  int mo_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet();
    m_req = '0; m_arvalid = '0; m_rready = '0;
    m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    quiet();
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    mo_owned = 0; mo_rel = 0; mo_owner = 0; mo_ptr = 0;
    mo_q.delete();
  endtask

  task automatic model_check();
    logic [N-1:0] e_grnt, e_arr, e_rv;
    bit e_arv, e_rr, cap;
    cap    = mo_q.size() < 3;
    e_grnt = mo_owned ? N'(1 << mo_owner) : '0;
    e_arv  = mo_owned && m_arvalid[mo_owner] && cap;
    e_arr  = (mo_owned && s_arready && cap) ? N'(1 << mo_owner) : '0;
    e_rv   = (mo_owned && s_rvalid) ? N'(1 << mo_owner) : '0;
    e_rr   = mo_owned && m_rready[mo_owner];
    chk("rnd_grnt", 64'(m_grnt), 64'(e_grnt));
    chk("rnd_busy", 64'(bus_busy), 64'(mo_owned));
    chk("rnd_arvalid", 64'(s_arvalid), 64'(e_arv));
    chk("rnd_arready", 64'(m_arready), 64'(e_arr));
    chk("rnd_rvalid", 64'(m_rvalid), 64'(e_rv));
    chk("rnd_rready", 64'(s_rready), 64'(e_rr));
    chk("rnd_rdata", 64'(m_rdata), 64'(s_rdata));
    if (e_arv) chk("rnd_araddr", 64'(s_araddr), 64'(m_araddr[mo_owner*AW +: AW]));
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (mo_owned) begin
      if (m_arvalid[mo_owner] && s_arready && mo_q.size() < 3)
        mo_q.push_back(int'(m_arlen[mo_owner*4 +: 4]));
      if (s_rvalid && m_rready[mo_owner] && s_rlast && mo_q.size() > 0)
        void'(mo_q.pop_front());
      if (!m_req[mo_owner] && mo_q.size() == 0) begin
        mo_owned = 0;
        mo_rel   = 1;
      end
    end else if (mo_rel) begin
      mo_ptr = (mo_owner + 1) % N;
      mo_rel = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!mo_owned && m_req[(mo_ptr + k) % N]) begin
          mo_owned = 1;
          mo_owner = (mo_ptr + k) % N;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    quiet();
    tbl[0] = '{-1, 3'b001, 3'b001};
    tbl[1] = '{-1, 3'b110, 3'b010};
    tbl[2] = '{-1, 3'b101, 3'b001};
    tbl[3] = '{-1, 3'b111, 3'b001};
    tbl[4] = '{ 0, 3'b101, 3'b100};
    tbl[5] = '{ 1, 3'b011, 3'b001};
    tbl[6] = '{ 2, 3'b110, 3'b010};
    tbl[7] = '{ 1, 3'b111, 3'b100};

    // reset state
    do_reset();
    settle();
    chk("rst_grnt", 64'(m_grnt), 64'd0);
    chk("rst_busy", 64'(bus_busy), 64'd0);
    chk("rst_arvalid", 64'(s_arvalid), 64'd0);
    chk("rst_rready", 64'(s_rready), 64'd0);
    chk("rst_arready", 64'(m_arready), 64'd0);
    chk("rst_rvalid", 64'(m_rvalid), 64'd0);
    chk("const_lock_cache_prot", 64'({s_arlock, s_arcache, s_arprot}),
        64'({AXI_ARLOCK, AXI_ARCACHE, AXI_ARPROT}));

    // stray R beat while idle
    s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 3'b111;
    settle();
    chk("stray_rready", 64'(s_rready), 64'd0);
    chk("stray_rvalid", 64'(m_rvalid), 64'd0);
    nxt();
    quiet();

    // arbitration table
    for (int t = 0; t < 8; t++) begin
      do_reset();
      if (tbl[t].pre >= 0) begin
        m_req = N'(1 << tbl[t].pre);
        nxt();
        m_req = '0;
        nxt();
        nxt();
      end
      m_req = tbl[t].req;
      settle();
      chk($sformatf("tbl%0d_nogrant_yet", t), 64'(m_grnt), 64'd0);
      nxt();
      settle();
      chk($sformatf("tbl%0d_grnt", t), 64'(m_grnt), 64'(tbl[t].exp));
      chk($sformatf("tbl%0d_busy", t), 64'(bus_busy), 64'd1);
    end

    // single master: grant latency, AR passthrough, R routing
    do_reset();
    m_req = 3'b100;
    settle();
    chk("single_grnt_c0", 64'(m_grnt), 64'd0);
    nxt();
    settle();
    chk("single_grnt_c1", 64'(m_grnt), 64'(3'b100));
    chk("single_busy_c1", 64'(bus_busy), 64'd1);
    m_arvalid = 3'b100; m_araddr[2*AW +: AW] = 32'h1FC0_0010; m_arid[2*IW +: IW] = 4'h5;
    s_arready = 1'b1;
    settle();
    chk("single_araddr", 64'(s_araddr), 64'h1FC0_0010);
    chk("single_arid", 64'(s_arid), 64'h5);
    chk("single_arvalid", 64'(s_arvalid), 64'd1);
    chk("single_arready", 64'(m_arready), 64'(3'b100));
    nxt();
    m_arvalid = '0; s_arready = 1'b0; m_req = '0;
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rlast = 1'b1; s_rid = 4'h5; m_rready = 3'b100;
    settle();
    chk("single_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    chk("single_rvalid", 64'(m_rvalid), 64'(3'b100));
    chk("single_rready", 64'(s_rready), 64'd1);
    chk("single_rlast", 64'(m_rlast), 64'd1);
    nxt();
    quiet();
    settle();
    chk("single_release_grnt", 64'(m_grnt), 64'd0);
    chk("single_release_busy", 64'(bus_busy), 64'd0);

    // contention: grants 0,1,2,0 each followed by a release cycle
    do_reset();
    m_req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      int k;
      k = 0;
      settle();
      while (m_grnt == '0 && k < 8) begin
        nxt();
        settle();
        k++;
      end
      chk($sformatf("cont_grant%0d", g), 64'(m_grnt), 64'(1 << (g % N)));
      chk($sformatf("cont_busy%0d", g), 64'(bus_busy), 64'd1);
      m_req[g % N] = 1'b0;
      nxt();
      settle();
      chk($sformatf("cont_rel_grnt%0d", g), 64'(m_grnt), 64'd0);
      chk($sformatf("cont_rel_busy%0d", g), 64'(bus_busy), 64'd0);
      m_req[g % N] = 1'b1;
    end

    // early req drop: grant held until last rlast, then master 2 after a release
    do_reset();
    m_req = 3'b010;
    nxt();
    m_arvalid = 3'b010; s_arready = 1'b1;
    nxt();
    m_arvalid = '0; s_arready = 1'b0; m_req = 3'b100;
    settle();
    chk("drop_hold1", 64'(m_grnt), 64'(3'b010));
    nxt();
    settle();
    chk("drop_hold2", 64'(m_grnt), 64'(3'b010));
    chk("drop_hold2_busy", 64'(bus_busy), 64'd1);
    s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 3'b010;
    settle();
    chk("drop_rvalid", 64'(m_rvalid), 64'(3'b010));
    nxt();
    quiet();
    m_req = 3'b100;
    settle();
    chk("drop_release_grnt", 64'(m_grnt), 64'd0);
    chk("drop_release_busy", 64'(bus_busy), 64'd0);
    nxt();
    settle();
    chk("drop_idle_grnt", 64'(m_grnt), 64'd0);
    nxt();
    settle();
    chk("drop_next_owner", 64'(m_grnt), 64'(3'b100));

    // outstanding cap of 3
    do_reset();
    m_req = 3'b001;
    nxt();
    m_arvalid = 3'b001; s_arready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("cap_ar%0d", k), 64'(s_arvalid), 64'd1);
      nxt();
    end
    settle();
    chk("cap_4th_arvalid", 64'(s_arvalid), 64'd0);
    chk("cap_4th_arready", 64'(m_arready), 64'd0);
    s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 3'b001;
    settle();
    chk("cap_still_stalled", 64'(s_arvalid), 64'd0);
    nxt();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    settle();
    chk("cap_resume_arvalid", 64'(s_arvalid), 64'd1);
    chk("cap_resume_arready", 64'(m_arready), 64'(3'b001));

    // reset in the middle of a 4-beat burst
    do_reset();
    m_req = 3'b001;
    nxt();
    m_arvalid = 3'b001; m_arlen[3:0] = 4'd3; s_arready = 1'b1;
    settle();
    chk("mid_arlen", 64'(s_arlen), 64'd3);
    nxt();
    m_arvalid = '0; s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b0; m_rready = 3'b001;
    nxt();
    nxt();
    rst_n = 1'b0;
    nxt();
    settle();
    chk("mid_rst_grnt", 64'(m_grnt), 64'd0);
    chk("mid_rst_busy", 64'(bus_busy), 64'd0);
    chk("mid_rst_rready", 64'(s_rready), 64'd0);
    chk("mid_rst_rvalid", 64'(m_rvalid), 64'd0);
    rst_n = 1'b1;
    quiet();
    m_req = 3'b001;
    nxt();
    settle();
    chk("mid_rst_regrant", 64'(m_grnt), 64'(3'b001));
    m_arvalid = 3'b001; s_arready = 1'b1;
    settle();
    chk("mid_rst_cnt_cleared", 64'(s_arvalid), 64'd1);

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      m_req     = N'($urandom);
      m_arvalid = N'($urandom);
      m_rready  = N'($urandom);
      m_araddr  = {$urandom, $urandom, $urandom};
      m_arid    = N*IW'($urandom);
      m_arlen   = N*4'($urandom);
      m_arsize  = N*3'($urandom);
      m_arburst = N*2'($urandom);
      s_arready = 1'($urandom);
      s_rdata   = $urandom;
      s_rid     = IW'($urandom);
      s_rresp   = 2'($urandom);
      s_rlast   = 1'($urandom);
      s_rvalid  = (mo_owned && mo_q.size() == 0) ? 1'b0 : 1'($urandom);
      settle();
      model_check();
      model_step();
      nxt();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
